// File: rtl/mmio_uart_tx_if.sv
// CPU data-memory port as seen by the memory-mapped UART transmitter.
// The CPU side drives address, store strobe and data; the peripheral returns read data and its select.
interface mmio_uart_tx_if;
    logic [31:0] addr;
    logic [1:0]  mem_write;
    logic [31:0] write_data;
    logic [2:0]  write_length;
    logic [31:0] read_data;
    logic        sel;

    modport master (
        output addr, mem_write, write_data, write_length,
        input  read_data, sel
    );

    modport slave (
        input  addr, mem_write, write_data, write_length,
        output read_data, sel
    );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA stores are queued in a small FIFO and serialised on tx.
// STATUS is a combinational read so the single-cycle core can load it in the same cycle.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0400,
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic          clock,
    input  logic          rstn,
    mmio_uart_tx_if.slave bus,
    output logic          tx
);
    localparam int unsigned PW          = $clog2(FIFO_DEPTH);
    localparam int unsigned CW          = PW + 1;
    localparam logic [31:0] STATUS_ADDR = BASE_ADDR + 32'd4;
    localparam logic [15:0] BAUD_LAST   = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [15:0]   baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          overflow;

    logic hit_data, hit_stat, store, full, empty, busy, push, drop, pop;
    logic unused_bits;

    assign hit_data    = (bus.addr[31:2] == BASE_ADDR[31:2]);
    assign hit_stat    = (bus.addr[31:2] == STATUS_ADDR[31:2]);
    assign store       = |bus.mem_write;
    assign full        = (count == CW'(FIFO_DEPTH));
    assign empty       = (count == '0);
    assign busy        = (state_q != IDLE);
    assign push        = store & hit_data & ~full;
    assign drop        = store & hit_data & full;
    assign bus.sel     = hit_data | hit_stat;
    assign tx          = tx_q;
    assign unused_bits = ^{bus.write_length, bus.write_data[31:8], bus.addr[1:0]};

    always_comb begin
        bus.read_data = '0;
        if (hit_stat) begin
            bus.read_data[0]       = busy;
            bus.read_data[1]       = full;
            bus.read_data[2]       = empty;
            bus.read_data[3]       = overflow;
            bus.read_data[4 +: CW] = count;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= bus.write_data[7:0];
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (store && hit_stat) overflow <= 1'b0;
            else if (drop)         overflow <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    // tx_d is the line level for the cycle after this edge, so tx comes straight from a flop.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr];
                    baud_d  = '0;
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    state_d = IDLE;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: a cycle-level FIFO/line-occupancy model predicts pops and STATUS,
// and an independent monitor decodes frames on tx and checks them against the predicted queue.
module tb_mmio_uart_tx;
    localparam int unsigned C     = 4;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0000_0400;
    localparam logic [31:0] STAT  = 32'h0000_0404;
    localparam logic [31:0] DMADR = 32'h0000_0100;

    logic clock = 1'b0;
    logic rstn  = 1'b0;
    logic tx;

    mmio_uart_tx_if bus_if();

    mmio_uart_tx #(
        .BASE_ADDR   (BASE),
        .CLKS_PER_BIT(C),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clock(clock),
        .rstn (rstn),
        .bus  (bus_if),
        .tx   (tx)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int fails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: queued bytes, sticky overflow, and the edge at which the line becomes free again.
    typedef struct {
        logic [7:0] data;
        longint     pop_edge;
    } frame_t;

    logic [7:0] mq[$];
    frame_t     sb[$];
    bit         ovf        = 1'b0;
    longint     edge_cnt   = 0;
    longint     busy_until = -1;

    always @(posedge clock or negedge rstn) begin
        int     pre;
        bit     st, hd, hs;
        frame_t f;
        if (!rstn) begin
            mq.delete();
            sb.delete();
            ovf        = 1'b0;
            busy_until = -1;
        end else begin
            edge_cnt++;
            pre = mq.size();
            st  = (bus_if.mem_write != 2'd0);
            hd  = (bus_if.addr[31:2] == BASE[31:2]);
            hs  = (bus_if.addr[31:2] == STAT[31:2]);
            if (pre > 0 && edge_cnt > busy_until) begin
                f.data     = mq.pop_front();
                f.pop_edge = edge_cnt;
                sb.push_back(f);
                busy_until = edge_cnt + 10 * C;
            end
            if (st && hd) begin
                if (pre < DEPTH) mq.push_back(bus_if.write_data[7:0]);
                else             ovf = 1'b1;
            end
            if (st && hs) ovf = 1'b0;
        end
    end

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        int          n;
        n    = mq.size();
        s    = '0;
        s[0] = (edge_cnt < busy_until);
        s[1] = (n == DEPTH);
        s[2] = (n == 0);
        s[3] = ovf;
        s[8:4] = 5'(n);
        return s;
    endfunction

    task automatic check_frame(input longint p, input logic [10*C-1:0] smp);
        logic [9:0] bits;
        bit         stable;
        frame_t     e;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bits[i] = smp[i*C + C/2];
            for (int k = 0; k < C; k++)
                if (smp[i*C + k] !== bits[i]) stable = 1'b0;
        end
        check("frame_start_bit", 32'(bits[0]), 32'd0);
        check("frame_stop_bit", 32'(bits[9]), 32'd1);
        check("frame_bit_stable", 32'(stable), 32'd1);
        if (sb.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL frame_unexpected: got byte 0x%0h at edge %0d, expected no frame", bits[8:1], p);
        end else begin
            e = sb.pop_front();
            check("frame_data", 32'(bits[8:1]), 32'(e.data));
            check("frame_start_edge", 32'(p), 32'(e.pop_edge));
        end
    endtask

    initial begin : monitor
        logic [10*C-1:0] smp;
        longint          p;
        bit              aborted;
        forever begin
            @(negedge clock);
            if (rstn === 1'b1 && tx === 1'b0) begin
                p       = edge_cnt;
                aborted = 1'b0;
                smp     = '0;
                smp[0]  = tx;
                for (int j = 1; j < 10 * C; j++) begin
                    @(negedge clock);
                    if (rstn !== 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    smp[j] = tx;
                end
                if (!aborted) check_frame(p, smp);
            end
        end
    end

    task automatic drive_idle();
        bus_if.addr         = DMADR;
        bus_if.mem_write    = 2'd0;
        bus_if.write_data   = $urandom;
        bus_if.write_length = 3'd0;
    endtask

    task automatic store(input logic [31:0] a, input logic [7:0] d);
        bus_if.addr         = a;
        bus_if.mem_write    = 2'($urandom_range(1, 3));
        bus_if.write_data   = {24'($urandom), d};
        bus_if.write_length = 3'($urandom);
        @(negedge clock);
        drive_idle();
    endtask

    task automatic probe(input string name, input logic [31:0] a, input logic [31:0] exp_rd, input logic exp_sel);
        bus_if.addr = a;
        #1;
        check({name, "_rd"}, bus_if.read_data, exp_rd);
        check({name, "_sel"}, 32'(bus_if.sel), 32'(exp_sel));
        bus_if.addr = DMADR;
    endtask

    task automatic check_status(input string name, input logic [31:0] exp_const);
        bus_if.addr = STAT;
        #1;
        check({name, "_status"}, bus_if.read_data, exp_const);
        check({name, "_model"}, bus_if.read_data, model_status());
        check({name, "_sel"}, 32'(bus_if.sel), 32'd1);
        bus_if.addr = DMADR;
    endtask

    task automatic wait_idle(input string name, input int bound);
        int n;
        n = 0;
        while (!(mq.size() == 0 && sb.size() == 0 && !(edge_cnt < busy_until)) && n < bound) begin
            @(negedge clock);
            n++;
        end
        check({name, "_drain"}, 32'(n < bound), 32'd1);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stimulus
        longint     target;
        int         n;
        int         r;
        int         rate;
        logic [31:0] a;
        bit         st;

        drive_idle();
        rstn = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_tx", 32'(tx), 32'd1);
        check_status("reset", 32'h004);
        probe("reset_dm", DMADR, 32'h0, 1'b0);
        @(negedge clock);
        rstn = 1'b1;

        // Single byte: latency, STATUS mid-frame and address decode.
        @(negedge clock);
        store(BASE, 8'h55);
        check("t1_tx_before_pop", 32'(tx), 32'd1);
        @(negedge clock);
        check("t1_tx_start", 32'(tx), 32'd0);
        check_status("t1_busy", 32'h005);
        probe("t1_addr_406", 32'h406, 32'h005, 1'b1);
        probe("t1_addr_400", BASE, 32'h0, 1'b1);
        probe("t1_addr_100", DMADR, 32'h0, 1'b0);
        wait_idle("t1", 100);
        @(negedge clock);
        check_status("t1_done", 32'h004);

        // Burst of six stores into a depth-4 FIFO, then clear overflow.
        @(negedge clock);
        for (int i = 0; i < 5; i++) store(BASE, 8'hA1 + 8'(i));
        check_status("ovf_full", 32'h043);
        store(BASE, 8'hA6);
        check_status("ovf_set", 32'h04B);
        store(STAT, 8'($urandom));
        check_status("ovf_clr", 32'h043);
        wait_idle("ovf", 400);

        // Store landing on the same edge as the STOP->IDLE pop.
        @(negedge clock);
        store(BASE, 8'hB1);
        store(BASE, 8'hB2);
        n = 0;
        while (edge_cnt != busy_until && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("pp_reach_stop_end", 32'(n < 100), 32'd1);
        store(BASE, 8'hB3);
        check_status("pp", 32'h011);
        wait_idle("pp", 200);

        // Store outside both registers.
        @(negedge clock);
        probe("nm_sel", 32'h008, 32'h0, 1'b0);
        store(32'h008, 8'hFF);
        check("nm_tx", 32'(tx), 32'd1);
        check_status("nm", 32'h004);
        repeat (3) @(negedge clock);
        check("nm_tx_later", 32'(tx), 32'd1);

        // Asynchronous reset in the middle of data bit 3.
        @(negedge clock);
        store(BASE, 8'hC3);
        store(BASE, 8'h5A);
        target = busy_until - 10 * C + 4 * C + C / 2;
        n = 0;
        while (edge_cnt < target && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("rst_reach_bit3", 32'(n < 100), 32'd1);
        check("rst_pre_tx", 32'(tx), 32'd0);
        #2;
        rstn = 1'b0;
        #1;
        check("rst_tx_async", 32'(tx), 32'd1);
        check_status("rst_during", 32'h004);
        @(negedge clock);
        @(negedge clock);
        rstn = 1'b1;
        @(negedge clock);
        check_status("rst_after", 32'h004);
        store(BASE, 8'h3C);
        wait_idle("rst", 200);

        // Random traffic with alternating heavy and light store rates.
        @(negedge clock);
        for (int i = 0; i < 480; i++) begin
            rate = ((i / 60) % 2 == 0) ? 40 : 4;
            r    = int'($urandom_range(0, 99));
            st   = 1'b1;
            if (r < rate)           a = BASE | 32'($urandom_range(0, 3));
            else if (r < rate + 4)  a = STAT | 32'($urandom_range(0, 3));
            else if (r < rate + 10) a = 32'($urandom_range(0, 511));
            else begin
                st = 1'b0;
                case ($urandom_range(0, 2))
                    0:       a = BASE | 32'($urandom_range(0, 3));
                    1:       a = STAT | 32'($urandom_range(0, 3));
                    default: a = 32'($urandom_range(0, 511));
                endcase
            end
            bus_if.addr         = a;
            bus_if.mem_write    = st ? 2'($urandom_range(1, 3)) : 2'd0;
            bus_if.write_data   = $urandom;
            bus_if.write_length = 3'($urandom);
            #1;
            check("rnd_sel", 32'(bus_if.sel),
                  32'((a[31:2] == BASE[31:2]) || (a[31:2] == STAT[31:2])));
            check("rnd_rd", bus_if.read_data,
                  (a[31:2] == STAT[31:2]) ? model_status() : 32'h0);
            @(negedge clock);
        end
        drive_idle();
        wait_idle("rnd", 1000);
        @(negedge clock);
        check_status("final", 32'h004);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
Memory-mapped UART transmitter on the CPU data-memory port, alongside the data memory in the SOPC. The CPU writes bytes through the same store path it uses for data memory, and the block queues them in a small FIFO. The bytes are serialised 8N1 on a TX pin. A combinational status register is readable by loads in the same cycle, which suits the single-cycle core.

Parameters:
BASE_ADDR, 32'h0000_0400, byte address of the TXDATA register; STATUS is at BASE_ADDR+4; must sit outside the 0x000-0x1FF data-memory window.
CLKS_PER_BIT, 868, clock cycles per serial bit (50 MHz / 57600); legal range 2 to 65535.
FIFO_DEPTH, 4, number of FIFO entries; must be a power of 2, from 2 to 16.

Ports:
clock  input  1  system clock, rising edge.
rstn  input  1  asynchronous active-low reset.
addr  input  32  CPU data address (AluResult).
mem_write  input  2  CPU MemWrite; any nonzero value means a store.
write_data  input  32  CPU store data; only [7:0] is used.
write_length  input  3  store length code; ignored, all store widths are accepted.
read_data  output  32  combinational read data for the selected register, 0 otherwise.
sel  output  1  high when addr[31:2] matches TXDATA or STATUS; the SOPC uses it to mux read data and to gate DM writes.
tx  output  1  serial output; idles high.

Behaviour:
- Reset (rstn low, asynchronous): tx=1, FSM=IDLE, FIFO empty (read and write pointers and count = 0), overflow=0, bit counter and baud counter = 0. read_data and sel stay combinational from addr and state.
- Decode uses word granularity on addr[31:2]; addr[1:0] is ignored.
- Push: on a clock edge with mem_write!=0 and a TXDATA hit:
  - if the FIFO is not full, write_data[7:0] is written and count is incremented;
  - fullness is judged from pre-edge state, so a write to a full FIFO is dropped even if a pop occurs on the same edge;
  - a dropped write sets overflow (sticky).
- A store to STATUS clears overflow; the written data is ignored.
- Simultaneous push and pop: both happen and count is unchanged.
- STATUS read_data layout:
  - [0] busy (FSM!=IDLE)
  - [1] full
  - [2] empty
  - [3] overflow
  - [8:4] count
  - all other bits 0
- A TXDATA read returns 0.
- FSM states IDLE, START, DATA, STOP; one baud counter counts 0..CLKS_PER_BIT-1.
  - IDLE: tx=1. If the FIFO is non-empty at the edge, pop the head into the shift register, clear the baud counter and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, LSB first. The register shifts right after each bit; after bit index 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
- STOP to IDLE to START costs one extra idle cycle, so back-to-back frames are separated by a stop bit of exactly CLKS_PER_BIT+1 cycles.
- Latency: a push into an empty FIFO at edge N is popped at edge N+1, so tx falls after edge N+1.
- A frame is 10*CLKS_PER_BIT cycles from start-bit fall to the end of the stop bit.
- FIFO pointers are log2(FIFO_DEPTH) bits wide and wrap naturally. Count is one bit wider than the pointers, so full means count==FIFO_DEPTH.
- Reset mid-frame aborts the frame: tx goes to 1 immediately and all queued data is lost.
- tx is driven from a register, so it never glitches.

Test Plan:
- Reset, CLKS_PER_BIT=4: store 0x55 to 0x400 → tx falls on the 2nd edge after the store. Bits sampled mid-bit read 0,1,0,1,0,1,0,1,0,1 (start, LSB first, stop), each 4 cycles long. STATUS reads 0x004 afterwards.
- STATUS during a frame: right after the pop, a load from 0x404 returns busy=1, empty=1, count=0, i.e. 0x005. sel=1 for 0x404 and for 0x406; sel=0 for 0x100.
- Overflow: 5 stores (0xA1..0xA5) on consecutive cycles with FIFO_DEPTH=4:
  - the first pop frees one slot, so all five are accepted and STATUS shows count=4, full=1 (0x043);
  - a 6th store of 0xA6 is dropped and sets overflow, STATUS 0x04B;
  - a store to 0x404 clears bit 3;
  - serial output is A1..A5 in order, with no A6.
- Push and pop on the same edge: with count=1 and the FSM in STOP→IDLE, store in the cycle the FIFO is popped → count stays 1 and data order is preserved.
- Non-matching store: store 0xFF to 0x008 → no FIFO change, tx stays 1, sel=0.
- Async reset mid-DATA bit 3: drop rstn without a clock edge → tx=1 at once. After release STATUS reads 0x004 and a new store transmits correctly.
